// File: rtl/pixel_result_collector.sv
// rtl/pixel_result_collector.sv - banked frame collector with done flag and random-access readout
module pixel_result_collector #(
  parameter int DW      = 8,
  parameter int NBANK   = 8,
  parameter int BANK_AW = 13
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic                                in_valid,
  input  logic [DW-1:0]                       in_pixel,
  output logic                                in_ready,
  output logic [NBANK-1:0]                    bank_we,
  output logic [BANK_AW-1:0]                  wr_addr,
  output logic                                busy,
  output logic                                done,
  output logic                                overflow,
  input  logic                                rd_en,
  input  logic [$clog2(NBANK)+BANK_AW-1:0]    rd_addr,
  output logic [DW-1:0]                       rd_data,
  output logic                                rd_valid
);

  localparam int BW    = $clog2(NBANK);
  localparam int CW    = BW + BANK_AW;
  localparam int DEPTH = 1 << BANK_AW;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

  state_t                   state;
  state_t                   state_nx;
  logic [CW-1:0]            cnt;
  logic                     accept;
  logic                     rd_fire;
  logic [BW-1:0]            wr_bank;
  logic [BANK_AW-1:0]       wr_off;
  logic [BW-1:0]            rd_bank;
  logic [BANK_AW-1:0]       rd_off;
  logic [BW-1:0]            rd_bank_q;
  logic [NBANK-1:0][DW-1:0] rd_bus;

  assign in_ready = (state == S_COLLECT);
  assign accept   = in_valid & in_ready;
  assign rd_fire  = rd_en & (state == S_DONE);
  assign wr_bank  = cnt[CW-1:BANK_AW];
  assign wr_off   = cnt[BANK_AW-1:0];
  assign rd_bank  = rd_addr[CW-1:BANK_AW];
  assign rd_off   = rd_addr[BANK_AW-1:0];

  // Read result is only meaningful while rd_valid is up; zero otherwise
  assign rd_data  = rd_valid ? rd_bus[rd_bank_q] : '0;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state: start always (re)enters collection; the last pixel of the frame ends it
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (start) state_nx = S_COLLECT;
      S_COLLECT: begin
        if (start) begin
          state_nx = S_COLLECT;
        end else if (accept && (&cnt)) begin
          state_nx = S_DONE;
        end
      end
      S_DONE:    if (start) state_nx = S_COLLECT;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Pixel counter, write trace, status flags and read handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      bank_we   <= '0;
      wr_addr   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_bank_q <= '0;
    end else begin
      if (start) begin
        cnt <= '0;
      end else if (accept) begin
        cnt <= cnt + CW'(1);
      end
      bank_we <= accept ? (NBANK'(1) << wr_bank) : '0;
      if (accept) begin
        wr_addr <= wr_off;
      end
      busy <= (state_nx == S_COLLECT);
      done <= (state_nx == S_DONE);
      if (start) begin
        overflow <= 1'b0;
      end else if (in_valid && !in_ready) begin
        overflow <= 1'b1;
      end
      rd_valid <= rd_fire;
      if (rd_fire) begin
        rd_bank_q <= rd_bank;
      end
    end
  end

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] q;

    // Per-bank RAM: write port fed by the pixel stream, registered read port for the host
    always_ff @(posedge clk) begin
      if (accept && (wr_bank == BW'(b))) begin
        mem[wr_off] <= in_pixel;
      end
      if (rd_fire && (rd_bank == BW'(b))) begin
        q <= mem[rd_off];
      end
    end

    assign rd_bus[b] = q;
  end

endmodule

// File: tb/tb_pixel_result_collector.sv
// tb/tb_pixel_result_collector.sv - scoreboard bench for pixel_result_collector
module tb_pixel_result_collector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic [7:0] in_pixel;
  logic       in_ready;
  logic [1:0] bank_we;
  logic [2:0] wr_addr;
  logic       busy;
  logic       done;
  logic       overflow;
  logic       rd_en;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       rd_valid;

  pixel_result_collector #(.DW(8), .NBANK(2), .BANK_AW(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_pixel(in_pixel),
    .in_ready(in_ready), .bank_we(bank_we), .wr_addr(wr_addr), .busy(busy), .done(done),
    .overflow(overflow), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  int nchk  = 0;
  int nfail = 0;

  // reference model: 0 idle, 1 collecting, 2 frame complete
  int         ref_state = 0;
  int         ref_cnt   = 0;
  bit         ref_ovf   = 0;
  logic [7:0] ref_mem [16];
  int         wq [$];
  logic [7:0] rq [$];

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: pops the scoreboard whenever the DUT shows a write trace or read result
  always @(negedge clk) begin
    if (rst_n) begin
      if (bank_we != 2'b00) begin
        if (wq.size() == 0) begin
          nchk++; nfail++;
          $display("FAIL trace_unexpected bank_we=%b wr_addr=%0d expected none", bank_we, wr_addr);
        end else begin
          int e;
          e = wq.pop_front();
          chk("trace_bank_we", int'(bank_we), 1 << (e / 8));
          chk("trace_wr_addr", int'(wr_addr), e % 8);
        end
      end
      if (rd_valid) begin
        if (rq.size() == 0) begin
          nchk++; nfail++;
          $display("FAIL read_unexpected rd_data=%0h expected no rd_valid", rd_data);
        end else begin
          logic [7:0] d;
          d = rq.pop_front();
          chk("rd_data", int'(rd_data), int'(d));
        end
      end
    end
  end

  task automatic step(input logic s, input logic v, input logic [7:0] p,
                      input logic re, input logic [3:0] ra);
    bit acc;
    start = s; in_valid = v; in_pixel = p; rd_en = re; rd_addr = ra;
    chk("in_ready", int'(in_ready), int'(ref_state == 1));
    chk("busy",     int'(busy),     int'(ref_state == 1));
    chk("done",     int'(done),     int'(ref_state == 2));
    chk("overflow", int'(overflow), int'(ref_ovf));
    if (re && ref_state == 2) rq.push_back(ref_mem[ra]);
    acc = v && (ref_state == 1);
    if (acc) begin
      ref_mem[ref_cnt] = p;
      wq.push_back(ref_cnt);
    end
    if (s) ref_ovf = 0;
    else if (v && ref_state != 1) ref_ovf = 1;
    if (s) begin
      ref_state = 1;
      ref_cnt   = 0;
    end else if (acc) begin
      if (ref_cnt == 15) begin
        ref_state = 2;
        ref_cnt   = 0;
      end else begin
        ref_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // mode 0: contiguous base+n, mode 1: valid toggled 1/0, mode 2: random gaps and data
  task automatic frame(input int mode, input logic [7:0] base);
    int n = 0;
    int guard = 0;
    while (ref_state == 1 && guard < 200) begin
      logic v;
      logic [7:0] p;
      case (mode)
        0:       v = 1'b1;
        1:       v = (guard % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      p = (mode == 2) ? 8'($urandom) : base + 8'(n);
      step(1'b0, v, p, 1'b0, 4'd0);
      if (v) n++;
      guard++;
    end
    chk("frame_completed", int'(ref_state == 2), 1);
  endtask

  task automatic readback_all();
    for (int a = 0; a < 16; a++) step(1'b0, 1'b0, 8'h00, 1'b1, 4'(a));
    step(1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 0);
    chk({tag, "_bank_we"},  int'(bank_we),  0);
    chk({tag, "_wr_addr"},  int'(wr_addr),  0);
    chk({tag, "_busy"},     int'(busy),     0);
    chk({tag, "_done"},     int'(done),     0);
    chk({tag, "_overflow"}, int'(overflow), 0);
    chk({tag, "_rd_data"},  int'(rd_data),  0);
    chk({tag, "_rd_valid"}, int'(rd_valid), 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_pixel = '0; rd_en = 1'b0; rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // pixel offered in IDLE is dropped and flags overflow
    step(1'b0, 1'b1, 8'hAA, 1'b0, 4'd0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 4'd2);

    // start with a coincident pixel: cleared overflow, pixel not taken; then full frame
    step(1'b1, 1'b1, 8'h55, 1'b0, 4'd0);
    frame(0, 8'h10);
    step(1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 4'd0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 4'd7);
    step(1'b0, 1'b0, 8'h00, 1'b1, 4'd8);
    step(1'b0, 1'b0, 8'h00, 1'b1, 4'd15);
    step(1'b0, 1'b0, 8'h00, 1'b0, 4'd0);

    // overflow in DONE, data untouched
    step(1'b0, 1'b1, 8'hAA, 1'b0, 4'd0);
    readback_all();

    // gapped frame
    step(1'b1, 1'b1, 8'hAA, 1'b0, 4'd0);
    frame(1, 8'h20);
    readback_all();

    // restart after 5 accepts
    step(1'b1, 1'b0, 8'h00, 1'b0, 4'd0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h30 + 8'(i), 1'b0, 4'd0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 4'd0);
    frame(0, 8'h40);
    readback_all();

    // random frame with random reads
    step(1'b1, 1'b0, 8'h00, 1'b0, 4'd0);
    frame(2, 8'h00);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 4'($urandom_range(0, 15)));
    step(1'b0, 1'b0, 8'h00, 1'b0, 4'd0);

    // reset mid-frame after 10 accepts
    step(1'b1, 1'b0, 8'h00, 1'b0, 4'd0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'($urandom), 1'b0, 4'd0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
    rst_n = 1'b0; rd_en = 1'b1; rd_addr = 4'd3;
    #1;
    check_reset_outputs("midreset");
    ref_state = 0; ref_cnt = 0; ref_ovf = 0;
    @(posedge clk);
    #1;
    check_reset_outputs("midreset_hold");
    rst_n = 1'b1;
    step(1'b0, 1'b0, 8'h00, 1'b1, 4'd3);
    step(1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 4'd0);
    frame(2, 8'h00);
    readback_all();

    step(1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
    chk("trace_queue_drained", wq.size(), 0);
    chk("read_queue_drained", rq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/pixel_result_collector.md
Name: pixel_result_collector

Overview:
- Write-side counterpart of the banked 3x3 window memory used by the parallel filter datapath.
- Accepts the processed pixel stream from the filter pipeline, one pixel per accepted cycle, in raster order.
- Scatters pixels into NBANK sequentially filled output banks of depth 2^BANK_AW, asserts done when the frame is complete, then serves random-access readout to the host/dump logic.

Parameters:
- DW, 8, pixel width in bits
- NBANK, 8, number of output banks; power of two, >=2
- BANK_AW, 13, address width per bank (depth 8192)
- Derived CW = log2(NBANK)+BANK_AW, frame length FRAME = NBANK*2^BANK_AW (default 65536)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle pulse; begins or restarts frame collection
- in_valid  in  1  processed pixel present on in_pixel
- in_pixel  in  DW  processed pixel
- in_ready  out  1  collector accepts in_pixel this cycle
- bank_we  out  NBANK  registered one-hot trace of the bank written last cycle
- wr_addr  out  BANK_AW  registered in-bank address of the last write
- busy  out  1  high in COLLECT
- done  out  1  high in DONE (frame complete)
- overflow  out  1  sticky; pixel offered while not collecting
- rd_en  in  1  readout request, honoured only in DONE
- rd_addr  in  CW  readout address; bank = rd_addr[CW-1:BANK_AW], offset = low bits
- rd_data  out  DW  readout data
- rd_valid  out  1  rd_data valid

Behaviour:
- Reset values: state IDLE, cnt=0, in_ready=0, bank_we=0, wr_addr=0, busy=0, done=0, overflow=0, rd_data=0, rd_valid=0. Bank contents are not reset; reading before first write returns don't-care.
- States: IDLE, COLLECT, DONE.
  - IDLE -> COLLECT on start.
  - COLLECT -> DONE on acceptance when cnt==FRAME-1.
  - DONE -> COLLECT on start.
  - start in COLLECT restarts: cnt=0, data overwritten.
  - No other transitions.
- in_ready = (state==COLLECT); combinational from state.
- Accept = in_valid & in_ready.
  - On accept: bank[cnt[CW-1:BANK_AW]][cnt[BANK_AW-1:0]] <= in_pixel at the same edge; cnt increments.
  - cnt wraps to 0 on the final pixel.
  - No gaps are required; in_valid may drop for any number of cycles without side effects.
- Trace: bank_we and wr_addr are registered and show the write one cycle after accept. bank_we=0 in cycles following no accept.
- Bank order: bank 0 fills offsets 0..2^BANK_AW-1, then bank 1, and so on; strictly sequential.
- done and busy are registered from state. done rises the cycle after the final accept and holds until start or reset.
- overflow is set when in_valid=1 in IDLE or DONE. It is sticky and is cleared by start (start has priority over set in the same cycle). The offending pixel is dropped.
- start coincident with in_valid in IDLE/DONE: the pixel is not accepted (in_ready still 0 that cycle) and overflow is not set.
- Readout:
  - rd_en in DONE: rd_data <= bank[rd_addr], rd_valid=1 one cycle later. Back-to-back reads give one result per cycle.
  - rd_en outside DONE: ignored, rd_valid=0.
  - start with rd_en: read still completes, since DONE is the current state.
- Reset mid-frame: immediate return to reset values; partial data is discarded logically and a new start is required.
- Storage: per-bank synchronous single-write / single-read arrays (inferred RAM); write and read ports are independent.

Test Plan:
- Bench uses NBANK=2, BANK_AW=3 (FRAME=16).
- Full frame: start, then 16 consecutive pixels 0x10..0x1F -> bank_we 01 for 8 cycles then 10 for 8, wr_addr 0..7 twice; done=1 the cycle after the 16th accept; in_ready=0 after.
- Readback: in DONE, rd_en with rd_addr 0,7,8,15 back-to-back -> rd_data 0x10,0x17,0x18,0x1F on the following 4 cycles, rd_valid=1 each.
- Gapped input: in_valid toggled 1/0 over the frame -> identical bank contents; done after the 16th accept only; no overflow.
- Overflow: in_valid=1 in IDLE, and again in DONE with value 0xAA -> overflow=1; readback shows no 0xAA; next start clears overflow.
- Restart: start after 5 accepts, then 16 new pixels 0x40..0x4F -> readback shows only 0x40..0x4F; done timing as in the full-frame case.
- Reset mid-frame: rst_n low after 10 accepts -> all outputs 0 immediately; rd_en ignored; start then 16 pixels completes normally.
